// File: rtl/sdram_port_arbiter_pkg.sv
// Shared types and defaults for the SDRAM command-port arbiter.
// Imported by the arbiter top and its round-robin selector.
package sdram_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_e;

  localparam int DEF_MAX_HOLD   = 256;
  localparam int DEF_GAP_CYCLES = 2;
  localparam int ID_W           = 3;

endpackage

// File: rtl/sdram_rr_select.sv
// Combinational round-robin pick: first set req bit at or
// above rr_ptr, wrapping modulo NUM_PORTS.
module sdram_rr_select
  import sdram_port_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 2
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [ID_W-1:0]      rr_ptr,
  output logic [ID_W-1:0]      winner,
  output logic                 valid
);

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      int idx;
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (!valid && req[idx]) begin
        valid  = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin sharing of the SDRAM controller command port with
// bounded hold time and an enforced idle gap between grants.
module sdram_port_arbiter
  import sdram_port_arbiter_pkg::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 22,
  parameter int MAX_HOLD   = DEF_MAX_HOLD,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            req,
  input  logic [NUM_PORTS-1:0]            req_we,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_address,
  output logic [NUM_PORTS-1:0]            grant,
  output logic [ID_W-1:0]                 grant_id,
  output logic                            write_en,
  output logic                            read_en,
  output logic [ADDR_WIDTH-1:0]           address,
  input  logic                            sdram_ready
);

  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

  arb_state_e              state_q, state_d;
  logic [ID_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [HOLD_W-1:0]       hold_cnt_q, hold_cnt_d;
  logic [GAP_W-1:0]        gap_cnt_q, gap_cnt_d;
  logic [NUM_PORTS-1:0]    grant_q, grant_d;
  logic [ID_W-1:0]         grant_id_q, grant_id_d;
  logic                    write_en_q, write_en_d;
  logic                    read_en_q, read_en_d;
  logic [ADDR_WIDTH-1:0]   address_q, address_d;

  logic [ID_W-1:0]         winner;
  logic                    win_valid;
  logic                    sel_we;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic                    own_req;
  logic                    other_req;

  sdram_rr_select #(
    .NUM_PORTS (NUM_PORTS)
  ) u_rr_select (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .winner (winner),
    .valid  (win_valid)
  );

  always_comb begin
    sel_we   = 1'b0;
    sel_addr = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (ID_W'(p) == winner) begin
        sel_we   = req_we[p];
        sel_addr = req_address[p*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  assign own_req   = |(grant_q & req);
  assign other_req = |(req & ~grant_q);

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    hold_cnt_d = hold_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    write_en_d = write_en_q;
    read_en_d  = read_en_q;
    address_d  = address_q;
    unique case (state_q)
      ST_IDLE: begin
        if (sdram_ready && win_valid) begin
          grant_d    = NUM_PORTS'(1) << winner;
          grant_id_d = winner;
          address_d  = sel_addr;
          write_en_d = sel_we;
          read_en_d  = ~sel_we;
          rr_ptr_d   = (winner == ID_W'(NUM_PORTS - 1)) ?
                       '0 : winner + ID_W'(1);
          hold_cnt_d = '0;
          state_d    = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (hold_cnt_q != HOLD_LAST) hold_cnt_d = hold_cnt_q + 1'b1;
        // timeout only matters when someone else is waiting
        if (!own_req || (hold_cnt_q == HOLD_LAST && other_req)) begin
          grant_d    = '0;
          write_en_d = 1'b0;
          read_en_d  = 1'b0;
          gap_cnt_d  = '0;
          state_d    = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (gap_cnt_q < GAP_LAST) gap_cnt_d = gap_cnt_q + 1'b1;
        if (gap_cnt_q >= GAP_LAST && sdram_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      hold_cnt_q <= '0;
      gap_cnt_q  <= '0;
      grant_q    <= '0;
      grant_id_q <= '0;
      write_en_q <= 1'b0;
      read_en_q  <= 1'b0;
      address_q  <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      hold_cnt_q <= hold_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      write_en_q <= write_en_d;
      read_en_q  <= read_en_d;
      address_q  <= address_d;
    end
  end

  assign grant    = grant_q;
  assign grant_id = grant_id_q;
  assign write_en = write_en_q;
  assign read_en  = read_en_q;
  assign address  = address_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: vector table plus
// hand sequences for timeout, long hold, not-ready and reset.
module tb_sdram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [1:0]  req_we;
  logic [21:0] a0, a1;
  logic [43:0] req_address;
  logic [1:0]  grant;
  logic [2:0]  grant_id;
  logic        write_en, read_en;
  logic [21:0] address;
  logic        sdram_ready;

  int n_vec  = 0;
  int n_fail = 0;

  assign req_address = {a1, a0};

  always #5 clk = ~clk;

  sdram_port_arbiter #(
    .NUM_PORTS  (2),
    .ADDR_WIDTH (22),
    .MAX_HOLD   (8),
    .GAP_CYCLES (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_we      (req_we),
    .req_address (req_address),
    .grant       (grant),
    .grant_id    (grant_id),
    .write_en    (write_en),
    .read_en     (read_en),
    .address     (address),
    .sdram_ready (sdram_ready)
  );

  typedef struct {
    logic        rst, rdy;
    logic [1:0]  req, we;
    logic [21:0] a0, a1;
    logic [1:0]  g;
    logic [2:0]  gid;
    logic        wen, ren;
    logic [21:0] addr;
    logic        chk;
  } vec_t;

  vec_t tbl[15];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if ((write_en && read_en) || !$onehot0(grant)) begin
      n_fail++;
      $display("FAIL invariant: grant=%b we=%b re=%b",
               grant, write_en, read_en);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int bad;
    rst = 1'b1; sdram_ready = 1'b0;
    req = '0; req_we = '0; a0 = '0; a1 = '0;

    tbl[0]  = '{1,0,2'b00,2'b00,22'h0,22'h0,      2'b00,0,0,0,22'h0,1};
    tbl[1]  = '{0,1,2'b01,2'b01,22'h001234,22'h0, 2'b01,0,1,0,22'h001234,1};
    tbl[2]  = '{0,1,2'b00,2'b01,22'h001234,22'h0, 2'b00,0,0,0,22'h0,0};
    tbl[3]  = '{0,1,2'b00,2'b00,22'h0,22'h0,      2'b00,0,0,0,22'h0,0};
    tbl[4]  = '{0,1,2'b00,2'b00,22'h0,22'h0,      2'b00,0,0,0,22'h0,0};
    tbl[5]  = '{0,1,2'b00,2'b00,22'h0,22'h0,      2'b00,0,0,0,22'h0,0};
    tbl[6]  = '{1,1,2'b11,2'b00,22'h000aaa,22'h3fffff, 2'b00,0,0,0,22'h0,1};
    tbl[7]  = '{0,1,2'b11,2'b00,22'h000aaa,22'h3fffff,
                2'b01,0,0,1,22'h000aaa,1};
    tbl[8]  = '{0,1,2'b11,2'b00,22'h000aaa,22'h3fffff,
                2'b01,0,0,1,22'h000aaa,1};
    tbl[9]  = '{0,1,2'b10,2'b00,22'h000aaa,22'h3fffff, 2'b00,0,0,0,22'h0,0};
    tbl[10] = '{0,1,2'b10,2'b00,22'h000aaa,22'h3fffff, 2'b00,0,0,0,22'h0,0};
    tbl[11] = '{0,1,2'b10,2'b00,22'h000aaa,22'h3fffff, 2'b00,0,0,0,22'h0,0};
    tbl[12] = '{0,1,2'b10,2'b00,22'h000aaa,22'h3fffff,
                2'b10,1,0,1,22'h3fffff,1};
    tbl[13] = '{0,1,2'b10,2'b11,22'h0,22'h0,      2'b10,1,0,1,22'h3fffff,1};
    tbl[14] = '{0,1,2'b00,2'b00,22'h0,22'h0,      2'b00,0,0,0,22'h0,0};

    for (int i = 0; i < 15; i++) begin
      rst = tbl[i].rst; sdram_ready = tbl[i].rdy;
      req = tbl[i].req; req_we = tbl[i].we;
      a0 = tbl[i].a0;   a1 = tbl[i].a1;
      step();
      chk($sformatf("v%0d grant", i), 32'(grant), 32'(tbl[i].g));
      chk($sformatf("v%0d write_en", i), 32'(write_en), 32'(tbl[i].wen));
      chk($sformatf("v%0d read_en", i), 32'(read_en), 32'(tbl[i].ren));
      if (tbl[i].chk) begin
        chk($sformatf("v%0d grant_id", i), 32'(grant_id), 32'(tbl[i].gid));
        chk($sformatf("v%0d address", i), 32'(address), 32'(tbl[i].addr));
      end
    end

    // timeout release with port1 waiting
    req = '0; do_reset();
    sdram_ready = 1'b1; req = 2'b01; req_we = 2'b01; a0 = 22'h000010;
    step();
    chk("to grant0", 32'(grant), 32'h1);
    req = 2'b11; req_we = 2'b01; a1 = 22'h000020;
    bad = 0;
    for (int k = 1; k < 8; k++) begin
      step();
      if (grant != 2'b01 || !write_en) bad++;
    end
    chk("to held 7 cycles", 32'(bad), 32'd0);
    step();
    chk("to release at 8", 32'(grant), 32'h0);
    chk("to release we", 32'(write_en), 32'h0);
    bad = 0;
    for (int k = 0; k < 2; k++) begin
      step();
      if (grant != 2'b00 || write_en || read_en) bad++;
    end
    chk("to gap idle", 32'(bad), 32'd0);
    step();
    chk("to grant1", 32'(grant), 32'h2);
    chk("to grant1 read_en", 32'(read_en), 32'h1);
    chk("to grant1 address", 32'(address), 32'h000020);

    // single requester is never preempted
    req = '0; do_reset();
    req = 2'b01; req_we = 2'b00;
    step();
    bad = 0;
    for (int k = 0; k < 1000; k++) begin
      step();
      if (grant != 2'b01 || !read_en) bad++;
    end
    chk("alone held", 32'(bad), 32'd0);
    chk("alone hold_cnt sat", 32'(dut.hold_cnt_q), 32'd7);

    // controller not ready blocks all grants
    req = '0; do_reset();
    sdram_ready = 1'b0; req = 2'b11; req_we = 2'b10;
    a0 = 22'h155555; a1 = 22'h2aaaaa;
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      step();
      if (grant != 2'b00 || write_en || read_en) bad++;
    end
    chk("notready no grant", 32'(bad), 32'd0);
    sdram_ready = 1'b1;
    step();
    chk("ready grant", 32'(grant), 32'h1);
    chk("ready address", 32'(address), 32'h155555);

    // reset mid-transaction
    rst = 1'b1;
    step();
    chk("rst grant", 32'(grant), 32'h0);
    chk("rst enables", 32'({write_en, read_en}), 32'h0);
    chk("rst address", 32'(address), 32'h0);
    rst = 1'b0;
    step();
    chk("post-rst grant", 32'(grant), 32'h1);
    chk("post-rst grant_id", 32'(grant_id), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Shares the single SDRAM controller command interface between NUM_PORTS requesters, e.g. the wishbone slave and a DMA or video port.
- Drives the controller's write_en, read_en and address inputs, and observes its sdram_ready output.
- Uses round-robin arbitration with a bounded hold time.
- Inserts a release gap between grants so the controller returns to its READY state before the next command.

Parameters:
- NUM_PORTS, 2, number of requesters (2..8).
- ADDR_WIDTH, 22, SDRAM word address width; matches the controller address port.
- MAX_HOLD, 256, cycles a grant may be held while another port is waiting.
- GAP_CYCLES, 2, minimum cycles with write_en and read_en both low between grants.

Ports:
- clk  in  1  system clock (same domain as the controller's wishbone-side inputs).
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_PORTS  per-port request, level; held for the whole transaction.
- req_we  in  NUM_PORTS  per-port direction: 1 = write, 0 = read; sampled at grant.
- req_address  in  NUM_PORTS*ADDR_WIDTH  per-port start address, packed with port 0 in the LSBs; sampled at grant.
- grant  out  NUM_PORTS  one-hot grant, registered.
- grant_id  out  3  index of the granted port; valid while grant != 0.
- write_en  out  1  to the controller; registered.
- read_en  out  1  to the controller; registered.
- address  out  ADDR_WIDTH  to the controller; registered.
- sdram_ready  in  1  from the controller: initialisation done and idle/serviceable.

Behaviour:
- Reset values: grant=0, grant_id=0, write_en=0, read_en=0, address=0. Internal: state=IDLE, rr_ptr=0, hold_cnt=0, gap_cnt=0.
- Reset asserted mid-transaction forces all of the above on the next edge; no completion handshake is performed.
- States: IDLE, ACTIVE, RELEASE.
- IDLE:
  - If sdram_ready=1 and req!=0, pick the winner: the first set req bit at or above rr_ptr, wrapping modulo NUM_PORTS.
  - On the next edge: grant=onehot(winner), grant_id=winner, address=req_address[winner].
  - On the same edge: write_en=req_we[winner], read_en=~req_we[winner], rr_ptr=(winner+1) mod NUM_PORTS, hold_cnt=0, go to ACTIVE.
  - Latency is one cycle from req sampled to grant/en high.
  - If sdram_ready=0, no grant is issued and all requests wait.
- ACTIVE:
  - write_en and read_en are held steady; req_we and req_address changes are ignored.
  - hold_cnt increments and saturates at MAX_HOLD-1.
  - Release condition: granted req=0, OR (hold_cnt==MAX_HOLD-1 AND another req bit is set).
  - On release, on the next edge: grant=0, write_en=0, read_en=0, gap_cnt=0, go to RELEASE.
  - If no other port is requesting, the grant is held indefinitely; there is no forced release.
  - Granted req dropping in the same cycle as a timeout counts as one release; there is no double action.
- RELEASE:
  - Both enables stay low; gap_cnt increments.
  - When gap_cnt>=GAP_CYCLES-1 and sdram_ready=1, go to IDLE; arbitration occurs there on the following cycle.
  - The total idle gap is therefore at least GAP_CYCLES+1 cycles.
- Invariants:
  - write_en and read_en are never both 1.
  - grant is zero or one-hot.
  - Enables are only high in ACTIVE.
- NUM_PORTS=1: rr_ptr stays at 0; timeout release never fires.

Decomposition:
- Add state encodings and the MAX_HOLD/GAP_CYCLES defaults as `defines in the shared sdram include file, alongside the existing SDRAM timing constants.
- One natural combinational sub-module: sdram_rr_select.
  - Inputs: req vector, rr_ptr.
  - Outputs: winner index and a valid flag.
  - Also reusable for future multi-port FIFO scheduling.

Test Plan:
- Reset then sdram_ready=1; req=2'b01, req_we[0]=1, req_address port0=22'h00_1234 -> one cycle later grant=01, write_en=1, read_en=0, address=22'h001234. Drop req -> next edge grant=0, write_en=0.
- Both ports request at rr_ptr=0 -> port0 granted first. After port0 releases and the RELEASE gap ends -> port1 granted, and grant is never 11.
- MAX_HOLD=8; port0 holds req, port1 requests at grant+1 -> grant drops exactly 8 cycles after grant. After GAP_CYCLES+1 idle cycles port1 granted with read_en=1.
- Port0 holds alone for 1000 cycles -> grant is never released and hold_cnt saturates.
- sdram_ready=0 with req=11 for 50 cycles -> no grant and both enables stay 0. Raise sdram_ready -> port at rr_ptr granted on the next edge.
- rst pulsed for one cycle during ACTIVE -> next edge grant=0, both enables=0, address=0; with req still set, the next grant after rst deasserts goes to port0 (rr_ptr=0).
